// File: rtl/sha3_stream_pkg.sv
// Shared types and size tables for the Keccak digest output stage.
package sha3_stream_pkg;

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5,
        MODE_FULL     = 3'd6,
        MODE_RSVD     = 3'd7
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT_PERM
    } fsm_t;

    localparam int          STATE_BYTES     = 200;
    localparam logic [15:0] BYTES_SHA3_224  = 16'd28;
    localparam logic [15:0] BYTES_SHA3_256  = 16'd32;
    localparam logic [15:0] BYTES_SHA3_384  = 16'd48;
    localparam logic [15:0] BYTES_SHA3_512  = 16'd64;
    localparam logic [15:0] BYTES_FULL      = 16'd200;
    localparam logic [7:0]  RATE_SHAKE128   = 8'd168;
    localparam logic [7:0]  RATE_SHAKE256   = 8'd136;

    function automatic logic [15:0] total_bytes(input mode_t m, input logic [15:0] len);
        case (m)
            MODE_SHA3_224: return BYTES_SHA3_224;
            MODE_SHA3_384: return BYTES_SHA3_384;
            MODE_SHA3_512: return BYTES_SHA3_512;
            MODE_SHAKE128,
            MODE_SHAKE256: return len;
            MODE_FULL:     return BYTES_FULL;
            default:       return BYTES_SHA3_256;
        endcase
    endfunction

    function automatic logic [7:0] block_bytes(input mode_t m);
        case (m)
            MODE_SHA3_224: return BYTES_SHA3_224[7:0];
            MODE_SHA3_384: return BYTES_SHA3_384[7:0];
            MODE_SHA3_512: return BYTES_SHA3_512[7:0];
            MODE_SHAKE128: return RATE_SHAKE128;
            MODE_SHAKE256: return RATE_SHAKE256;
            MODE_FULL:     return BYTES_FULL[7:0];
            default:       return BYTES_SHA3_256[7:0];
        endcase
    endfunction

endpackage

// File: rtl/sha3_word_select.sv
// Picks one beat of bytes out of the 1600-bit state at a byte pointer,
// orders them for the stream and zero-fills bytes beyond the valid count.
module sha3_word_select
    import sha3_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_SWAP  = 1
) (
    input  logic [1599:0]           i_state,
    input  logic [7:0]              i_ptr,
    input  logic [3:0]              i_nbytes,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_keep
);

    localparam int BPB = DATA_WIDTH / 8;

    always_comb begin : sel
        int idx;
        int lane;
        o_data = '0;
        o_keep = '0;
        for (int k = 0; k < BPB; k++) begin
            idx  = int'(i_ptr) + k;
            lane = (BYTE_SWAP != 0) ? (BPB - 1 - k) : k;
            if (k < int'(i_nbytes) && idx < STATE_BYTES) begin
                o_data[lane*8 +: 8] = i_state[idx*8 +: 8];
                o_keep[lane]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha3_stream_out.sv
// Serialises a finished Keccak state onto an AXI4-Stream port, squeezing
// further SHAKE blocks on demand until the requested byte count is out.
module sha3_stream_out
    import sha3_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_SWAP  = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [1599:0]           s_state,
    input  logic                    s_state_valid,
    output logic                    s_state_ready,
    input  logic [2:0]              mode,
    input  logic [15:0]             out_len,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    squeeze_req
);

    localparam int          BPB   = DATA_WIDTH / 8;
    localparam logic [15:0] BPB16 = 16'(BPB);

    fsm_t                    r_fsm, w_fsm_nxt;
    logic [1599:0]           r_state;
    logic [15:0]             r_rem, w_rem_nxt, w_rem_adv, w_step, w_tot;
    logic [7:0]              r_ptr, w_ptr_nxt, w_ptr_adv;
    logic [7:0]              r_blk, w_blk_nxt;
    logic                    r_tvalid, r_tlast, r_sq;
    logic [DATA_WIDTH-1:0]   r_tdata, w_sel_data;
    logic [BPB-1:0]          r_tkeep, w_sel_keep;
    logic                    w_accept, w_load, w_beat_ld, w_vld_nxt, w_sq_nxt, w_last;
    logic [3:0]              w_nbytes;

    assign s_state_ready = (r_fsm != ST_STREAM);
    assign w_accept      = r_tvalid & m_axis_tready;
    assign w_step        = (r_rem > BPB16) ? BPB16 : r_rem;
    assign w_rem_adv     = r_rem - w_step;
    assign w_ptr_adv     = r_ptr + w_step[7:0];
    assign w_tot         = total_bytes(mode_t'(mode), out_len);

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_load    = 1'b0;
        w_beat_ld = 1'b0;
        w_vld_nxt = r_tvalid;
        w_sq_nxt  = 1'b0;
        w_rem_nxt = r_rem;
        w_ptr_nxt = r_ptr;
        w_blk_nxt = r_blk;
        case (r_fsm)
            ST_IDLE: begin
                // A zero-length SHAKE request consumes the state and produces nothing.
                if (s_state_valid && w_tot != 16'd0) begin
                    w_load    = 1'b1;
                    w_beat_ld = 1'b1;
                    w_vld_nxt = 1'b1;
                    w_rem_nxt = w_tot;
                    w_ptr_nxt = 8'd0;
                    w_blk_nxt = block_bytes(mode_t'(mode));
                    w_fsm_nxt = ST_STREAM;
                end
            end
            ST_WAIT_PERM: begin
                if (s_state_valid) begin
                    w_load    = 1'b1;
                    w_beat_ld = 1'b1;
                    w_vld_nxt = 1'b1;
                    w_ptr_nxt = 8'd0;
                    w_fsm_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_accept) begin
                    w_rem_nxt = w_rem_adv;
                    w_ptr_nxt = w_ptr_adv;
                    if (w_rem_adv == 16'd0) begin
                        w_vld_nxt = 1'b0;
                        w_fsm_nxt = ST_IDLE;
                    end else if (w_ptr_adv == r_blk) begin
                        w_vld_nxt = 1'b0;
                        w_sq_nxt  = 1'b1;
                        w_fsm_nxt = ST_WAIT_PERM;
                    end else begin
                        w_beat_ld = 1'b1;
                    end
                end
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // The next beat is formed from the incoming state on a load so the
    // first beat is already registered one cycle after the handshake.
    assign w_nbytes = (w_rem_nxt > BPB16) ? 4'(BPB) : w_rem_nxt[3:0];
    assign w_last   = (w_rem_nxt <= BPB16);

    sha3_word_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_SWAP  (BYTE_SWAP)
    ) u_sel (
        .i_state  (w_load ? s_state : r_state),
        .i_ptr    (w_ptr_nxt),
        .i_nbytes (w_nbytes),
        .o_data   (w_sel_data),
        .o_keep   (w_sel_keep)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_fsm    <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_sq     <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
        end else begin
            r_fsm    <= w_fsm_nxt;
            r_tvalid <= w_vld_nxt;
            r_sq     <= w_sq_nxt;
            if (w_beat_ld) begin
                r_tdata <= w_sel_data;
                r_tkeep <= w_sel_keep;
                r_tlast <= w_last;
            end else if (!w_vld_nxt) begin
                r_tlast <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_load) r_state <= s_state;
        r_rem <= w_rem_nxt;
        r_ptr <= w_ptr_nxt;
        r_blk <= w_blk_nxt;
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign squeeze_req   = r_sq;

endmodule
